box_drawer: RTL and testbench

BOX_DRAWER -- requirements
Module: box_drawer

---
 rtl/box_drawer.sv | 86 ++++++++
 tb/tb_box_drawer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_drawer.sv
// box_drawer: fixed-size box rasteriser with a 2-deep request FIFO, one pixel per cycle
// to a VGA adapter write port; pixel outputs are combinational from the draw state.
module box_drawer #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_colour,
    output logic       req_ready,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       box_done,
    output logic       busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DRAW = 1'b1;

    logic [0:0]  state;
    logic [17:0] mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic [3:0]  cx, cy;
    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic [2:0]  base_c;
    logic        push, pop, last, row_end;
    logic [8:0]  sum_x;
    logic [7:0]  sum_y;

    assign req_ready = count < 2'd2;
    assign push      = req_valid && req_ready;
    assign row_end   = cx == 4'(BOX_W - 1);
    assign last      = state == DRAW && row_end && cy == 4'(BOX_H - 1);
    // Popping on the last pixel keeps consecutive boxes bubble-free.
    assign pop       = count != 2'd0 && (state == IDLE || last);
    assign sum_x     = {1'b0, base_x} + {5'd0, cx};
    assign sum_y     = {1'b0, base_y} + {4'd0, cy};
    assign x         = sum_x[7:0];
    assign y         = sum_y[6:0];
    assign colour    = base_c;
    assign plot      = state == DRAW && sum_x < 9'd160 && sum_y < 8'd120;
    assign busy      = state == DRAW || count != 2'd0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_x, req_y, req_colour};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cx       <= 4'd0;
            cy       <= 4'd0;
            base_x   <= 8'd0;
            base_y   <= 7'd0;
            base_c   <= 3'd0;
            box_done <= 1'b0;
        end else begin
            count    <= count + 2'(push) - 2'(pop);
            wr_ptr   <= wr_ptr ^ push;
            rd_ptr   <= rd_ptr ^ pop;
            box_done <= last;
            if (pop) begin
                {base_x, base_y, base_c} <= mem[rd_ptr];
                cx    <= 4'd0;
                cy    <= 4'd0;
                state <= DRAW;
            end else if (last) begin
                cx    <= 4'd0;
                cy    <= 4'd0;
                state <= IDLE;
            end else if (state == DRAW) begin
                cx <= row_end ? 4'd0 : cx + 4'd1;
                cy <= row_end ? cy + 4'd1 : cy;
            end
        end
    end
endmodule

// File: tb/tb_box_drawer.sv
// tb_box_drawer: randomized checks of box_drawer against a per-cycle schedule model
// built from acceptance times (pop = max(accept+1, previous pop + W*H)).
module tb_box_drawer;
    localparam int W = 4, H = 3, WH = W * H, MAXC = 8192;

    logic clk = 1'b0, resetn = 1'b0, req_valid = 1'b0;
    logic [7:0] req_x = 8'd0;
    logic [6:0] req_y = 7'd0;
    logic [2:0] req_colour = 3'd0;
    logic req_ready, plot, box_done, busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    int cyc = 0, checks = 0, fails = 0;
    logic [21:0] obs_v [MAXC];
    logic [21:0] exp_v [MAXC];
    int rq_x[$], rq_y[$], rq_c[$], rq_off[$];
    int acc_x[$], acc_y[$], acc_c[$], acc_n[$];

    box_drawer #(.BOX_W(W), .BOX_H(H)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .req_ready(req_ready), .x(x), .y(y), .colour(colour),
        .plot(plot), .box_done(box_done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {plot, x, y, colour, box_done, busy, req_ready}; pixel fields zeroed when not plotting
    function automatic logic [21:0] pack(input logic p, input logic [7:0] px, input logic [6:0] py,
                                         input logic [2:0] pc, input logic d, input logic b, input logic r);
        return p ? {1'b1, px, py, pc, d, b, r} : {1'b0, 18'd0, d, b, r};
    endfunction

    always @(negedge clk) if (cyc < MAXC) obs_v[cyc] <= pack(plot, x, y, colour, box_done, busy, req_ready);

    task automatic build_model(input int t0, input int t1);
        int p[$];
        int cnt, j, sx, sy, cc;
        logic pl, dn, bs;
        for (int i = 0; i < acc_n.size(); i++)
            p.push_back(i == 0 ? acc_n[0] + 1 : (acc_n[i] + 1 > p[i-1] + WH ? acc_n[i] + 1 : p[i-1] + WH));
        for (int e = t0; e < t1; e++) begin
            cnt = 0; pl = 0; dn = 0; bs = 0; sx = 0; sy = 0; cc = 0;
            for (int i = 0; i < acc_n.size(); i++) begin
                if (e >= p[i] && e < p[i] + WH) begin
                    j = e - p[i];
                    sx = acc_x[i] + j % W;
                    sy = acc_y[i] + j / W;
                    cc = acc_c[i];
                    pl = sx < 160 && sy < 120;
                end
                if (e == p[i] + WH) dn = 1;
                if (e >= acc_n[i] && e < p[i] + WH) bs = 1;
                if (e >= acc_n[i] && e < p[i]) cnt++;
            end
            exp_v[e] = pack(pl, 8'(sx), 7'(sy), 3'(cc), dn, bs, cnt < 2);
        end
    endtask

    task automatic clear_q();
        rq_x.delete(); rq_y.delete(); rq_c.delete(); rq_off.delete();
        acc_x.delete(); acc_y.delete(); acc_c.delete(); acc_n.delete();
    endtask

    task automatic do_reset(output int t0);
        @(negedge clk);
        resetn = 0;
        req_valid = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
        @(negedge clk);
        t0 = cyc;
    endtask

    task automatic add_req(input int rx, input int ry, input int rc, input int off);
        rq_x.push_back(rx); rq_y.push_back(ry); rq_c.push_back(rc); rq_off.push_back(off);
    endtask

    // Called at a negedge; each request held from t0+offset until accepted.
    task automatic drive(input int t0);
        int k;
        for (int i = 0; i < rq_x.size(); i++) begin
            while (cyc + 1 < t0 + rq_off[i]) @(negedge clk);
            req_valid = 1; req_x = 8'(rq_x[i]); req_y = 7'(rq_y[i]); req_colour = 3'(rq_c[i]);
            k = 0;
            while (!req_ready && k < 200) begin @(negedge clk); k++; end
            checks++;
            if (!req_ready) begin
                fails++;
                $display("FAIL accept_timeout req %0d: req_ready=%b required 1", i, req_ready);
            end else begin
                acc_x.push_back(rq_x[i]); acc_y.push_back(rq_y[i]); acc_c.push_back(rq_c[i]);
                acc_n.push_back(cyc + 1);
            end
            @(negedge clk);
            req_valid = 0;
        end
    endtask

    task automatic drain(output int t1);
        int k = 0;
        while (busy && k < 400) begin @(negedge clk); k++; end
        checks++;
        if (busy) begin fails++; $display("FAIL drain_timeout: busy=%b required 0", busy); end
        repeat (3) @(negedge clk);
        t1 = cyc;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({plot, box_done, busy, x, y, colour} !== 21'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0", {plot, box_done, busy, x, y, colour});
        end
        resetn = 1;
        @(negedge clk);
        checks++;
        if ({req_ready, busy, plot} !== 3'b100) begin
            fails++;
            $display("FAIL reset_release: ready/busy/plot got %b required 100", {req_ready, busy, plot});
        end
    endtask

    task automatic test_single();
        int t0, t1;
        do_reset(t0);
        clear_q();
        add_req(38, 4, 7, 1);
        drive(t0);
        drain(t1);
        build_model(t0, t1);
        for (int e = t0; e < t1; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                fails++;
                if (fails < 40) $display("FAIL single cycle %0d: got %h required %h", e - t0, obs_v[e], exp_v[e]);
            end
        end
        checks++;
        if (obs_v[acc_n[0]] !== pack(0, 0, 0, 0, 0, 1, 1) || obs_v[acc_n[0] + 1] !== pack(1, 38, 4, 7, 0, 1, 1)) begin
            fails++;
            $display("FAIL single_latency: got %h,%h required first pixel 2 cycles after accept",
                     obs_v[acc_n[0]], obs_v[acc_n[0] + 1]);
        end
    endtask

    task automatic test_clip();
        int t0, t1, n = 0;
        do_reset(t0);
        clear_q();
        add_req(158, 118, 3, 1);
        drive(t0);
        drain(t1);
        build_model(t0, t1);
        for (int e = t0; e < t1; e++) begin
            n += int'(obs_v[e][21]);
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                fails++;
                if (fails < 40) $display("FAIL clip cycle %0d: got %h required %h", e - t0, obs_v[e], exp_v[e]);
            end
        end
        checks++;
        if (n != 4) begin fails++; $display("FAIL clip_count: plotted %0d required 4", n); end
    endtask

    task automatic test_back_to_back();
        int t0, t1, np = 0, nd = 0;
        do_reset(t0);
        clear_q();
        for (int i = 0; i < 4; i++) add_req($urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(0, 7), 1);
        drive(t0);
        drain(t1);
        build_model(t0, t1);
        for (int e = t0; e < t1; e++) begin
            np += int'(obs_v[e][21]);
            nd += int'(obs_v[e][2]);
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                fails++;
                if (fails < 40) $display("FAIL b2b cycle %0d: got %h required %h", e - t0, obs_v[e], exp_v[e]);
            end
        end
        checks++;
        if (acc_n[1] - acc_n[0] != 1 || acc_n[2] - acc_n[0] != 2 || acc_n[3] - acc_n[0] != WH + 2) begin
            fails++;
            $display("FAIL b2b_accept: offsets %0d %0d %0d required 1 2 %0d",
                     acc_n[1] - acc_n[0], acc_n[2] - acc_n[0], acc_n[3] - acc_n[0], WH + 2);
        end
        checks++;
        if (np != 4 * WH || nd != 4) begin
            fails++;
            $display("FAIL b2b_counts: plots %0d done %0d required %0d 4", np, nd, 4 * WH);
        end
    endtask

    task automatic test_push_pop();
        int t0, t1;
        do_reset(t0);
        clear_q();
        add_req(10, 10, 1, 1);
        add_req(20, 20, 2, 3);
        add_req(30, 30, 5, 2 + WH);
        drive(t0);
        drain(t1);
        build_model(t0, t1);
        for (int e = t0; e < t1; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                fails++;
                if (fails < 40) $display("FAIL push_pop cycle %0d: got %h required %h", e - t0, obs_v[e], exp_v[e]);
            end
        end
        checks++;
        if (acc_n[2] != acc_n[0] + 1 + WH || obs_v[acc_n[2]][0] !== 1'b1) begin
            fails++;
            $display("FAIL push_pop_edge: accept %0d ready %b required %0d 1",
                     acc_n[2] - acc_n[0], obs_v[acc_n[2]][0], 1 + WH);
        end
    endtask

    task automatic test_random();
        int t0, t1, n, off;
        for (int r = 0; r < 4; r++) begin
            do_reset(t0);
            clear_q();
            n = $urandom_range(3, 6);
            off = 1;
            for (int i = 0; i < n; i++) begin
                add_req($urandom_range(0, 3) == 0 ? $urandom_range(150, 159) : $urandom_range(0, 159),
                        $urandom_range(0, 3) == 0 ? $urandom_range(110, 119) : $urandom_range(0, 119),
                        $urandom_range(0, 7), off);
                off += $urandom_range(0, 16);
            end
            drive(t0);
            drain(t1);
            build_model(t0, t1);
            for (int e = t0; e < t1; e++) begin
                checks++;
                if (obs_v[e] !== exp_v[e]) begin
                    fails++;
                    if (fails < 40) $display("FAIL random r%0d cycle %0d: got %h required %h", r, e - t0, obs_v[e], exp_v[e]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0, t1, k = 0;
        do_reset(t0);
        clear_q();
        add_req($urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(0, 7), 1);
        add_req(40, 40, 6, 2);
        drive(t0);
        while (cyc < acc_n[0] + 5 && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (plot !== 1'b1 || cyc != acc_n[0] + 5) begin
            fails++;
            $display("FAIL mid_pre: plot %b at cycle %0d required 1 at %0d", plot, cyc - acc_n[0], 5);
        end
        #2 resetn = 0;
        #1;
        checks++;
        if ({plot, busy, box_done} !== 3'b000) begin
            fails++;
            $display("FAIL mid_async: plot/busy/done got %b required 000", {plot, busy, box_done});
        end
        repeat (2) @(negedge clk);
        resetn = 1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: got %b required 1", req_ready); end
        t0 = cyc + 1;
        repeat (30) @(negedge clk);
        t1 = cyc;
        for (int e = t0; e < t1; e++) begin
            checks++;
            if (obs_v[e][21] !== 1'b0 || obs_v[e][1] !== 1'b0) begin
                fails++;
                if (fails < 40) $display("FAIL mid_after cycle %0d: plot/busy %b%b required 00", e - t0, obs_v[e][21], obs_v[e][1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clip();
        test_back_to_back();
        test_push_pop();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
